// File: rtl/cache_pkg.sv
// Shared types, geometry and address-slicing helpers for the direct-mapped L1 data cache.
package cache_pkg;
  localparam int SETS      = 16;
  localparam int LINE_BITS = 256;
  localparam int OFFSET_W  = 5;
  localparam int INDEX_W   = $clog2(SETS);
  localparam int TAG_W     = 32 - INDEX_W - OFFSET_W;
  localparam int WORDS     = LINE_BITS / 32;
  localparam int WSEL_W    = $clog2(WORDS);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    REFILL    = 2'd2,
    FILL      = 2'd3
  } state_e;

  function automatic logic [INDEX_W-1:0] addr_index(input logic [31:0] addr);
    return INDEX_W'(addr >> OFFSET_W);
  endfunction

  function automatic logic [TAG_W-1:0] addr_tag(input logic [31:0] addr);
    return TAG_W'(addr >> (OFFSET_W + INDEX_W));
  endfunction

  function automatic logic [WSEL_W-1:0] addr_wsel(input logic [31:0] addr);
    return WSEL_W'(addr >> 2);
  endfunction
endpackage

// File: rtl/dcache_sram.sv
// Tag/valid/dirty/data storage: combinational read of one set, posedge write of a full line or one word.
module dcache_sram
  import cache_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 start_i,
  input  logic [INDEX_W-1:0]   idx_i,
  input  logic                 line_we_i,
  input  logic                 word_we_i,
  input  logic [WSEL_W-1:0]    wsel_i,
  input  logic [31:0]          word_i,
  input  logic [TAG_W-1:0]     tag_i,
  input  logic [LINE_BITS-1:0] line_i,
  output logic [TAG_W-1:0]     tag_o,
  output logic                 valid_o,
  output logic                 dirty_o,
  output logic [LINE_BITS-1:0] line_o
);
  logic [SETS-1:0]      valid_q, valid_d;
  logic [SETS-1:0]      dirty_q, dirty_d;
  logic [TAG_W-1:0]     tag_mem  [SETS];
  logic [LINE_BITS-1:0] data_mem [SETS];

  assign tag_o   = tag_mem[idx_i];
  assign valid_o = valid_q[idx_i];
  assign dirty_o = dirty_q[idx_i];
  assign line_o  = data_mem[idx_i];

  // A line fill leaves the set clean; a word merge marks it dirty.
  always_comb begin
    valid_d = valid_q;
    dirty_d = dirty_q;
    if (line_we_i) begin
      valid_d[idx_i] = 1'b1;
      dirty_d[idx_i] = 1'b0;
    end else if (word_we_i) begin
      dirty_d[idx_i] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge start_i) begin
    if (!start_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (line_we_i) begin
      data_mem[idx_i] <= line_i;
      tag_mem[idx_i]  <= tag_i;
    end else if (word_we_i) begin
      data_mem[idx_i][{wsel_i, 5'b0} +: 32] <= word_i;
    end
  end
endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back, write-allocate L1 data cache controller: hit logic, miss FSM, memory handshake.
module dcache_ctrl
  import cache_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 start_i,
  input  logic [31:0]          cpu_addr_i,
  input  logic [31:0]          cpu_data_i,
  input  logic                 cpu_MemRead_i,
  input  logic                 cpu_MemWrite_i,
  output logic [31:0]          cpu_data_o,
  output logic                 cpu_stall_o,
  output logic                 mem_enable_o,
  output logic                 mem_write_o,
  output logic [31:0]          mem_addr_o,
  output logic [LINE_BITS-1:0] mem_data_o,
  input  logic [LINE_BITS-1:0] mem_data_i,
  input  logic                 mem_ack_i
);
  state_e               state_q, state_d;
  logic [LINE_BITS-1:0] fill_q, fill_d;
  logic [INDEX_W-1:0]   idx;
  logic [TAG_W-1:0]     tag;
  logic [WSEL_W-1:0]    wsel;
  logic [TAG_W-1:0]     rd_tag;
  logic                 rd_valid, rd_dirty;
  logic [LINE_BITS-1:0] rd_line;
  logic                 req, hit, line_we, word_we, stall;

  assign idx  = addr_index(cpu_addr_i);
  assign tag  = addr_tag(cpu_addr_i);
  assign wsel = addr_wsel(cpu_addr_i);
  assign req  = cpu_MemRead_i | cpu_MemWrite_i;
  assign hit  = req & rd_valid & (rd_tag == tag);

  dcache_sram u_sram (
    .clk_i     (clk_i),
    .start_i   (start_i),
    .idx_i     (idx),
    .line_we_i (line_we),
    .word_we_i (word_we),
    .wsel_i    (wsel),
    .word_i    (cpu_data_i),
    .tag_i     (tag),
    .line_i    (fill_q),
    .tag_o     (rd_tag),
    .valid_o   (rd_valid),
    .dirty_o   (rd_dirty),
    .line_o    (rd_line)
  );

  always_comb begin
    state_d      = state_q;
    fill_d       = fill_q;
    stall        = 1'b0;
    line_we      = 1'b0;
    word_we      = 1'b0;
    cpu_data_o   = '0;
    mem_enable_o = 1'b0;
    mem_write_o  = 1'b0;
    mem_addr_o   = '0;
    mem_data_o   = '0;
    unique case (state_q)
      IDLE: begin
        if (req & ~hit) begin
          stall   = 1'b1;
          state_d = rd_dirty ? WRITEBACK : REFILL;
        end else if (hit & cpu_MemWrite_i) begin
          word_we = 1'b1;
        end else if (hit) begin
          cpu_data_o = rd_line[{wsel, 5'b0} +: 32];
        end
      end
      WRITEBACK: begin
        stall        = 1'b1;
        mem_enable_o = 1'b1;
        mem_write_o  = 1'b1;
        mem_addr_o   = {rd_tag, idx, OFFSET_W'(0)};
        mem_data_o   = rd_line;
        if (mem_ack_i) state_d = REFILL;
      end
      REFILL: begin
        stall        = 1'b1;
        mem_enable_o = 1'b1;
        mem_addr_o   = {tag, idx, OFFSET_W'(0)};
        if (mem_ack_i) begin
          fill_d  = mem_data_i;
          state_d = FILL;
        end
      end
      FILL: begin
        stall   = 1'b1;
        line_we = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset forces the stall low even while a miss request is still being presented.
  assign cpu_stall_o = stall & start_i;

  always_ff @(posedge clk_i or negedge start_i) begin
    if (!start_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge clk_i) begin
    fill_q <= fill_d;
  end
endmodule
